// File: rtl/stopwatch_counter_pkg.sv
// rtl/stopwatch_counter_pkg.sv - shared types and constants for the BCD stopwatch
package stopwatch_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] TENTHS_MAX    = 4'd9;
    localparam logic [BCD_W-1:0] SEC_UNITS_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX  = 4'd5;
    localparam logic [BCD_W-1:0] MIN_UNITS_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one wrapping BCD digit of the stopwatch counting chain
module bcd_digit
    import stopwatch_counter_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             clk_in,
    input  logic             res,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] val,
    output logic             carry
);

    // Carry fires only on the increment that wraps this digit from MAX to zero.
    assign carry = inc & (val == MAX);

    // Digit register: clear wins, anything at or above MAX (including an illegal code) wraps to 0.
    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            val <= '0;
        end else if (clr) begin
            val <= '0;
        end else if (inc) begin
            if (val >= MAX) begin
                val <= '0;
            end else begin
                val <= val + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS.t BCD stopwatch driven by the 10 Hz divider output
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter bit               BOTH_EDGES   = 1'b1,
    parameter logic [BCD_W-1:0] MIN_TENS_MAX = 4'd5
) (
    input  logic        clk_in,
    input  logic        res,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [19:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    state_t            state;
    state_t            state_next;
    logic              tick_d;
    logic              ev;
    logic              count_en;
    logic [4:0]        carry;
    logic [BCD_W-1:0]  tenths;
    logic [BCD_W-1:0]  sec_units;
    logic [BCD_W-1:0]  sec_tens;
    logic [BCD_W-1:0]  min_units;
    logic [BCD_W-1:0]  min_tens;
    logic [19:0]       live;
    logic [19:0]       snap;

    // The divider output is treated as data; every transition (or rising edge) is one tenth.
    assign ev       = BOTH_EDGES ? (tick_in ^ tick_d) : (tick_in & ~tick_d);
    assign count_en = ev & (state == RUN) & ~clear;
    assign live     = {min_tens, min_units, sec_tens, sec_units, tenths};
    assign disp_bcd = lap_active ? snap : live;

    // Previous-cycle copy of tick_in for edge detection; keeps sampling through clear.
    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick_in;
        end
    end

    bcd_digit #(.MAX(TENTHS_MAX)) u_tenths (
        .clk_in(clk_in), .res(res), .inc(count_en), .clr(clear),
        .val(tenths), .carry(carry[0])
    );

    bcd_digit #(.MAX(SEC_UNITS_MAX)) u_sec_units (
        .clk_in(clk_in), .res(res), .inc(carry[0]), .clr(clear),
        .val(sec_units), .carry(carry[1])
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk_in(clk_in), .res(res), .inc(carry[1]), .clr(clear),
        .val(sec_tens), .carry(carry[2])
    );

    bcd_digit #(.MAX(MIN_UNITS_MAX)) u_min_units (
        .clk_in(clk_in), .res(res), .inc(carry[2]), .clr(clear),
        .val(min_units), .carry(carry[3])
    );

    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk_in(clk_in), .res(res), .inc(carry[3]), .clr(clear),
        .val(min_tens), .carry(carry[4])
    );

    // State register; running is registered alongside so it always matches state.
    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
        end
    end

    // Run/pause control: clear overrides start_stop.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            unique case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Lap freeze: snapshot taken from the pre-increment live count when freezing in RUN.
    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            lap_active <= 1'b0;
            snap       <= '0;
        end else if (clear) begin
            lap_active <= 1'b0;
        end else if (lap) begin
            unique case (state)
                RUN: begin
                    lap_active <= ~lap_active;
                    if (!lap_active) begin
                        snap <= live;
                    end
                end
                PAUSE:   lap_active <= 1'b0;
                default: lap_active <= lap_active;
            endcase
        end
    end

    // Sticky wrap flag, set when the top digit carries out of 59:59.9.
    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (carry[4]) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed and random checks of the stopwatch against a tenths-count model
module tb_stopwatch_counter;

    logic        clk_in = 1'b0;
    logic        res;
    logic        tick_in;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [19:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    int m_count;
    int m_snap;
    int m_state;
    bit m_lap;
    bit m_ovf;
    bit m_prev;

    stopwatch_counter dut (
        .clk_in(clk_in), .res(res), .tick_in(tick_in), .start_stop(start_stop),
        .lap(lap), .clear(clear), .disp_bcd(disp_bcd), .running(running),
        .lap_active(lap_active), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [19:0] to_bcd(input int n);
        int m, s, t;
        t = n % 10;
        s = (n / 10) % 60;
        m = n / 600;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t)};
    endfunction

    task automatic model_reset();
        m_count = 0; m_snap = 0; m_state = 0;
        m_lap = 0; m_ovf = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit t, input bit ss, input bit lp, input bit cl);
        bit ev;
        ev = (t != m_prev);
        m_prev = t;
        if (cl) begin
            m_count = 0; m_state = 0; m_lap = 0; m_ovf = 0;
        end else begin
            if (lp) begin
                if (m_state == 1) begin
                    if (m_lap) m_lap = 0;
                    else begin m_lap = 1; m_snap = m_count; end
                end else if (m_state == 2) begin
                    m_lap = 0;
                end
            end
            if (ev && m_state == 1) begin
                m_count = m_count + 1;
                if (m_count == 36000) begin m_count = 0; m_ovf = 1; end
            end
            if (ss) m_state = (m_state == 1) ? 2 : 1;
        end
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".disp"}, disp_bcd, to_bcd(m_lap ? m_snap : m_count));
        chk({tag, ".running"}, {19'd0, running}, {19'd0, m_state == 1});
        chk({tag, ".lap_active"}, {19'd0, lap_active}, {19'd0, m_lap});
        chk({tag, ".overflow"}, {19'd0, overflow}, {19'd0, m_ovf});
    endtask

    // One clock cycle: drive at negedge, model updates at posedge, sample at next negedge.
    task automatic cyc(input bit toggle, input bit ss, input bit lp, input bit cl);
        bit t;
        t = toggle ? ~tick_in : tick_in;
        tick_in = t; start_stop = ss; lap = lp; clear = cl;
        @(posedge clk_in);
        model_step(t, ss, lp, cl);
        @(negedge clk_in);
        start_stop = 0; lap = 0; clear = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    initial begin
        res = 1; tick_in = 0; start_stop = 0; lap = 0; clear = 0;
        model_reset();
        repeat (3) @(negedge clk_in);
        chk_model("reset");
        chk("reset.disp_const", disp_bcd, 20'h00000);
        res = 0;
        @(negedge clk_in);

        ticks(10);
        chk_model("idle_ticks");
        chk("idle_ticks.const", disp_bcd, 20'h00000);

        cyc(0, 1, 0, 0);
        ticks(123);
        chk_model("run123");
        chk("run123.const", disp_bcd, 20'h00123);
        cyc(0, 1, 0, 0);
        ticks(5);
        chk_model("paused");
        chk("paused.const", disp_bcd, 20'h00123);

        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        ticks(35999);
        chk_model("preload");
        chk("preload.const", disp_bcd, 20'h59599);
        ticks(1);
        chk_model("wrap");
        chk("wrap.const", {overflow, disp_bcd}, {1'b1, 20'h00000});
        ticks(3);
        chk_model("wrap_sticky");
        cyc(0, 0, 0, 1);
        chk_model("wrap_clear");
        chk("wrap_clear.ovf", {19'd0, overflow}, 20'd0);

        cyc(0, 1, 0, 0);
        ticks(42);
        cyc(0, 0, 1, 0);
        chk_model("lap_on");
        chk("lap_on.const", {lap_active, disp_bcd}, {1'b1, 20'h00042});
        ticks(20);
        chk_model("lap_frozen");
        chk("lap_frozen.const", disp_bcd, 20'h00042);
        cyc(0, 0, 1, 0);
        chk_model("lap_off");
        chk("lap_off.const", disp_bcd, 20'h00062);

        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        ticks(9);
        cyc(1, 1, 0, 0);
        chk_model("tick_stop");
        chk("tick_stop.const", {running, disp_bcd}, {1'b0, 20'h00010});
        cyc(1, 1, 0, 0);
        chk_model("tick_start_paused");
        chk("tick_start_paused.const", {running, disp_bcd}, {1'b1, 20'h00010});
        cyc(0, 1, 0, 1);
        chk_model("clear_ss");
        chk("clear_ss.const", {running, disp_bcd}, {1'b0, 20'h00000});

        cyc(1, 1, 1, 0);
        ticks(3);
        cyc(1, 1, 1, 0);
        chk_model("ss_lap_same");

        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        ticks(834);
        chk("pre_async.const", disp_bcd, 20'h01234);
        #2 res = 1;
        #1;
        model_reset();
        chk_model("async_res");
        chk("async_res.const", {running, lap_active, overflow, disp_bcd}, 23'd0);
        @(negedge clk_in);
        res = 0;
        ticks(5);
        chk_model("after_res_ticks");
        chk("after_res_ticks.const", disp_bcd, 20'h00000);
        cyc(0, 1, 0, 0);
        ticks(1);
        chk("after_res_start.const", disp_bcd, 20'h00001);

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
            if (i % 16 == 0) chk_model("random");
        end
        chk_model("random_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
